// File: rtl/picobello_pkg.sv
// Shared types and default timing constants for the tile power controller.
package picobello_pkg;

   // Default cycle counts for the power sequencer.
   localparam int DefClkSettleCycles = 4;
   localparam int DefRstHoldCycles   = 8;
   localparam int DefDrainTimeout    = 1024;

   // Power command opcode; value 3 is reserved and treated as a no-op.
   typedef enum logic [1:0] {
      OpOn    = 2'd0,
      OpOff   = 2'd1,
      OpReset = 2'd2,
      OpRsvd  = 2'd3
   } tile_pwr_op_e;

   // Sequencer state, exported on state_o.
   typedef enum logic [2:0] {
      Off      = 3'd0,
      WakeClk  = 3'd1,
      WakeRst  = 3'd2,
      On       = 3'd3,
      Drain    = 3'd4,
      SleepRst = 3'd5,
      SleepClk = 3'd6
   } tile_pwr_state_e;

endpackage

// File: rtl/tile_pwr_ctrl.sv
// Tile power sequencer: orders clock enable and reset release/assertion for
// one cluster tile, draining outstanding traffic before powering down.
// Ports:
//   clk_i, rst_i        single clock, synchronous active-high reset
//   req_valid_i/_ready_o command handshake, req_op_i command opcode
//   tile_idle_i         tile has no outstanding NoC/AXI traffic
//   tile_clk_en_o       tile clock enable
//   tile_rst_no         tile reset (active-low)
//   state_o             current sequencer state
//   err_timeout_o       sticky drain-timeout flag, cleared by clr_err_i
module tile_pwr_ctrl
   import picobello_pkg::*;
#(
   parameter int ClkSettleCycles = DefClkSettleCycles,
   parameter int RstHoldCycles   = DefRstHoldCycles,
   parameter int DrainTimeout    = DefDrainTimeout
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  tile_pwr_op_e    req_op_i,
   input  logic            tile_idle_i,
   output logic            tile_clk_en_o,
   output logic            tile_rst_no,
   output tile_pwr_state_e state_o,
   output logic            err_timeout_o,
   input  logic            clr_err_i
);

   localparam int MaxCyc0 = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
   localparam int MaxCyc  = (MaxCyc0 > DrainTimeout) ? MaxCyc0 : DrainTimeout;
   localparam int unsigned CntW = $clog2(MaxCyc + 1);

   if (ClkSettleCycles < 1 || RstHoldCycles < 1 || DrainTimeout < 1) begin : g_bad_param
      $error("tile_pwr_ctrl: all cycle parameters must be >= 1");
   end

   tile_pwr_state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rst_seq_q, rst_seq_d;   // current drain belongs to an OpReset
   logic            err_d;
   logic            clk_en_d, rst_n_d, ready_d;
   logic            accept;

   assign accept = req_valid_i && req_ready_o;

   // Next-state, counter reload and sticky error logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
      rst_seq_d = rst_seq_q;
      err_d     = err_timeout_o;
      if (clr_err_i) err_d = 1'b0;

      case (state_q)
         Off: begin
            if (accept && req_op_i == OpOn) begin
               state_d = WakeClk;
               cnt_d   = CntW'(ClkSettleCycles - 1);
            end
         end
         WakeClk: begin
            if (cnt_q == '0) begin
               state_d = WakeRst;
               cnt_d   = CntW'(RstHoldCycles - 1);
            end
         end
         WakeRst: begin
            if (cnt_q == '0) begin
               state_d   = On;
               cnt_d     = '0;
               rst_seq_d = 1'b0;
            end
         end
         On: begin
            if (accept && (req_op_i == OpOff || req_op_i == OpReset)) begin
               state_d   = Drain;
               cnt_d     = CntW'(DrainTimeout - 1);
               rst_seq_d = (req_op_i == OpReset);
            end
         end
         Drain: begin
            // Idle wins over an expiring counter; timeout still shuts down.
            if (tile_idle_i || cnt_q == '0) begin
               state_d = SleepRst;
               cnt_d   = CntW'(ClkSettleCycles - 1);
               if (!tile_idle_i) err_d = 1'b1;
            end
         end
         SleepRst: begin
            if (cnt_q == '0) begin
               if (rst_seq_q) begin
                  state_d = WakeRst;
                  cnt_d   = CntW'(RstHoldCycles - 1);
               end else begin
                  state_d = SleepClk;
                  cnt_d   = CntW'(ClkSettleCycles - 1);
               end
            end
         end
         SleepClk: begin
            if (cnt_q == '0) begin
               state_d = Off;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = Off;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode of the next state so the registered outputs track state_q.
   always_comb begin
      clk_en_d = 1'b0;
      rst_n_d  = 1'b0;
      ready_d  = 1'b0;
      case (state_d)
         Off:                        ready_d = 1'b1;
         WakeClk, WakeRst, SleepRst: clk_en_d = 1'b1;
         On: begin
            clk_en_d = 1'b1;
            rst_n_d  = 1'b1;
            ready_d  = 1'b1;
         end
         Drain: begin
            clk_en_d = 1'b1;
            rst_n_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counter and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= Off;
         cnt_q         <= '0;
         rst_seq_q     <= 1'b0;
         err_timeout_o <= 1'b0;
         tile_clk_en_o <= 1'b0;
         tile_rst_no   <= 1'b0;
         req_ready_o   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rst_seq_q     <= rst_seq_d;
         err_timeout_o <= err_d;
         tile_clk_en_o <= clk_en_d;
         tile_rst_no   <= rst_n_d;
         req_ready_o   <= ready_d;
      end
   end

   assign state_o = state_q;

endmodule
